sls_sequencer: RTL
==================

Name: sls_sequencer

Overview:
- Consumes the 8-bit entry-state code produced by the load/store addressing-mode encoder.
- Runs the matching single or multiple load/store micro-sequence: MAR load, memory request with MFC handshake, destination load and base write-back.
- Sits beside the main control unit. The control unit hands over on `start` and waits for `done` or `err`.

Parameters:
- CODE_W, 8, width of the entry-state code.
- NREGS, 16, width of the register list for load/store multiple.
- TIMEOUT_CYCLES, 255, MFC wait limit; used only with SLS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from the control unit; sampled only in IDLE.
- entry_code  in  CODE_W  encoder output. Legal values: 16, 17, 19, 21, 22, 23, 30, 31.
- is_load  in  1  IR[20]; 1 = load, 0 = store.
- up  in  1  IR[23]; 1 = add offset or step, 0 = subtract.
- wback  in  1  IR[21] write-back request; used for codes 30/31 only.
- reg_list  in  NREGS  IR[15:0] for codes 30/31.
- mfc  in  1  memory function complete.
- busy  out  1  high in every state except IDLE.
- mar_ld  out  1  load MAR from the address adder.
- addr_src  out  2  0 = Rn, 1 = Rn±offset, 2 = Rn±4, 3 = MAR±4.
- off_src  out  1  0 = immediate offset (codes 16/17/19), 1 = register offset (codes 21/22/23).
- mem_req  out  1  memory operation strobe; held until MFC.
- mem_rw  out  1  1 = read, 0 = write; equals latched is_load.
- rd_ld  out  1  destination register load; pulses for loads only.
- reg_idx  out  4  current register for multiple transfers; Rd path for singles (0).
- rn_wb  out  1  base write-back strobe.
- wb_src  out  1  0 = Rn±offset, 1 = MAR±4.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse for illegal code or empty register list.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE, all outputs 0, latched fields cleared. Takes effect immediately mid-operation; mem_req drops that cycle.
- Capture on `start` in IDLE: latches entry_code, is_load, up, wback and reg_list. `start` outside IDLE is ignored. Inputs are not re-sampled until the next IDLE.
- IDLE → ADDR on a legal code.
  - Exception: codes 30/31 with reg_list == 0 go to ERR.
- IDLE → ERR on any other code.
- ADDR (1 cycle):
  - mar_ld = 1.
  - addr_src: Rn for 17, 22 and 30; Rn±offset for 16, 19, 21 and 23; Rn±4 for 31; MAR±4 on every re-entry during a multiple.
  - → XFER.
- XFER:
  - mem_req = 1 and mem_rw = is_load until mfc = 1.
  - Cycle mfc = 1: rd_ld = is_load.
  - Multiple: the current bit is cleared in that cycle.
  - Next state: ADDR if any list bits remain; otherwise WB if write-back is needed; otherwise DONE.
  - mfc outside XFER is ignored.
- Write-back is needed for codes 17, 19, 22, 23, and for 30/31 when wback = 1.
- WB (1 cycle): rn_wb = 1. wb_src = 1 for 30/31, else 0. → DONE.
- DONE (1 cycle): done = 1, → IDLE.
- ERR (1 cycle): err = 1, → IDLE. No memory strobes are issued.
- Multiple transfers:
  - Registers are served lowest index first.
  - reg_idx is valid from ADDR through XFER of each transfer.
- Latency, single transfer with mfc in the first XFER cycle:
  - start at cycle 0.
  - ADDR at cycle 1.
  - XFER at cycle 2.
  - WB at cycle 3, if write-back is needed.
  - done at cycle 3 without write-back, cycle 4 with it.
- Multiple with N registers and immediate mfc: 2N cycles, plus 1 for WB, plus 1 for DONE.

Optional Feature:
- Macro: SLS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in XFER and clears on entry to XFER.
  - Reaching TIMEOUT_CYCLES without mfc drops mem_req and goes to ERR (err pulse).
  - No rd_ld or rn_wb is issued.
- Undefined: XFER waits indefinitely, and no counter logic exists.

Decomposition:
- Package sls_pkg holds:
  - the state enum (IDLE, ADDR, XFER, WB, DONE, ERR);
  - entry-code constants (SLS_IMM_OFF = 16, SLS_IMM_POST = 17, SLS_IMM_PRE = 19, SLS_REG_OFF = 21, SLS_REG_POST = 22, SLS_REG_PRE = 23, SLS_MUL_RN = 30, SLS_MUL_RN4 = 31);
  - the addr_src encodings.
- Sub-module sls_reg_picker: combinational lowest-set-bit finder. Outputs a 4-bit index and an `any` flag. Instantiated once.

Test Plan:
1. Code 16, is_load = 1, mfc on the first XFER cycle → mar_ld with addr_src = 1 at cycle 1; mem_req/mem_rw = 1 at cycle 2; rd_ld at cycle 2; done at cycle 3; rn_wb never asserted.
2. Code 22, store, mfc delayed 3 cycles → mem_req high 4 cycles with mem_rw = 0; rd_ld never asserted; rn_wb with wb_src = 0 one cycle after mfc; then done.
3. Code 31, reg_list = 0x0013, wback = 1, up = 1, load → three ADDR/XFER pairs with reg_idx 0, 1, 4; addr_src 2, 3, 3; three rd_ld pulses; rn_wb with wb_src = 1; then done.
4. Code 20, and separately code 30 with reg_list = 0 → err pulse at cycle 1; no mar_ld or mem_req; back in IDLE at cycle 2.
5. reset_n low during XFER of code 19, then start asserted during busy on a fresh run → all outputs 0 immediately on reset; the busy-time start is ignored; the next IDLE start runs normally.
6. With SLS_TIMEOUT_EN defined, code 17 and mfc held 0 → err after TIMEOUT_CYCLES XFER cycles; no rn_wb.

Source files
------------

// File: rtl/sls_pkg.sv
// Shared types and constants for the load/store micro-sequencer:
// state encoding, entry-state codes, address-source encodings and the
// entry-code decoder used when a request is captured.
package sls_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      XFER = 3'd2,
      WB   = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } sls_state_e;

   // Entry-state codes produced by the addressing-mode encoder
   localparam logic [7:0] SLS_IMM_OFF  = 8'd16;
   localparam logic [7:0] SLS_IMM_POST = 8'd17;
   localparam logic [7:0] SLS_IMM_PRE  = 8'd19;
   localparam logic [7:0] SLS_REG_OFF  = 8'd21;
   localparam logic [7:0] SLS_REG_POST = 8'd22;
   localparam logic [7:0] SLS_REG_PRE  = 8'd23;
   localparam logic [7:0] SLS_MUL_RN   = 8'd30;
   localparam logic [7:0] SLS_MUL_RN4  = 8'd31;

   // addr_src encodings
   localparam logic [1:0] SRC_RN     = 2'd0;
   localparam logic [1:0] SRC_RN_OFF = 2'd1;
   localparam logic [1:0] SRC_RN_4   = 2'd2;
   localparam logic [1:0] SRC_MAR_4  = 2'd3;

   // Everything the sequencer needs to know about an operation, decoded once
   typedef struct packed {
      logic       legal;
      logic       mul;        // load/store multiple
      logic       wb_need;    // base write-back (multiples: filled from wback)
      logic       reg_off;    // register offset rather than immediate
      logic [1:0] first_src;  // address source for the first ADDR cycle
   } sls_op_t;

   function automatic sls_op_t sls_decode(input logic [7:0] code);
      sls_op_t op;
      op = '0;
      op.legal = 1'b1;
      case (code)
         SLS_IMM_OFF:  op.first_src = SRC_RN_OFF;
         SLS_IMM_POST: begin op.first_src = SRC_RN;     op.wb_need = 1'b1; end
         SLS_IMM_PRE:  begin op.first_src = SRC_RN_OFF; op.wb_need = 1'b1; end
         SLS_REG_OFF:  begin op.first_src = SRC_RN_OFF; op.reg_off = 1'b1; end
         SLS_REG_POST: begin op.first_src = SRC_RN;     op.reg_off = 1'b1; op.wb_need = 1'b1; end
         SLS_REG_PRE:  begin op.first_src = SRC_RN_OFF; op.reg_off = 1'b1; op.wb_need = 1'b1; end
         SLS_MUL_RN:   begin op.first_src = SRC_RN;     op.mul = 1'b1; end
         SLS_MUL_RN4:  begin op.first_src = SRC_RN_4;   op.mul = 1'b1; end
         default:      op.legal = 1'b0;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/sls_reg_picker.sv
// Combinational lowest-set-bit finder over the remaining register list.
module sls_reg_picker #(
   parameter int NREGS = 16
) (
   input  logic [NREGS-1:0] req_bits,
   output logic [3:0]       idx,
   output logic             any
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = NREGS - 1; i >= 0; i--) begin
         if (req_bits[i]) begin
            idx = 4'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sls_sequencer.sv
// Load/store micro-sequencer: runs MAR load, memory request with MFC
// handshake, destination load and base write-back for single and multiple
// transfers. Optional MFC timeout enabled by defining SLS_TIMEOUT_EN.
module sls_sequencer
   import sls_pkg::*;
#(
   parameter int CODE_W         = 8,
   parameter int NREGS          = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [CODE_W-1:0] entry_code,
   input  logic              is_load,
   input  logic              up,
   input  logic              wback,
   input  logic [NREGS-1:0]  reg_list,
   input  logic              mfc,
   output logic              busy,
   output logic              mar_ld,
   output logic [1:0]        addr_src,
   output logic              off_src,
   output logic              mem_req,
   output logic              mem_rw,
   output logic              rd_ld,
   output logic [3:0]        reg_idx,
   output logic              rn_wb,
   output logic              wb_src,
   output logic              done,
   output logic              err
);

   sls_state_e       state_reg, state_next;
   sls_op_t          op_reg, cap_op;
   logic             is_load_reg, up_reg, first_reg;
   logic [NREGS-1:0] list_reg, cur_bit;
   logic [3:0]       pick_idx;
   logic             pick_any, rest_any, tmo_hit, code_hi_zero;

   sls_reg_picker #(.NREGS(NREGS)) u_picker (
      .req_bits (list_reg),
      .idx      (pick_idx),
      .any      (pick_any)
   );

   // Decode the incoming code; bits above the 8-bit code space make it illegal
   assign code_hi_zero = ((entry_code >> 8) == '0);
   always_comb begin
      cap_op = sls_decode(8'(entry_code));
      cap_op.legal = cap_op.legal & code_hi_zero;
      if (cap_op.mul)
         cap_op.wb_need = wback;
   end

   assign cur_bit  = NREGS'(1) << pick_idx;
   assign rest_any = |(list_reg & ~cur_bit);

`ifdef SLS_TIMEOUT_EN
   logic [7:0] tmo_cnt_reg;

   // Count XFER cycles; any other state clears, so each XFER entry starts at 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tmo_cnt_reg <= '0;
      else if (state_reg != XFER)
         tmo_cnt_reg <= '0;
      else
         tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
   end

   assign tmo_hit = (tmo_cnt_reg == 8'(TIMEOUT_CYCLES - 1));

   // up only steers the external address adder
   logic unused_ok;
   assign unused_ok = up_reg;
`else
   assign tmo_hit = 1'b0;

   // up only steers the external address adder; no timeout counter here
   logic unused_ok;
   assign unused_ok = up_reg ^ (TIMEOUT_CYCLES == 0);
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Latch the operation in IDLE; consume list bits as each transfer completes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_reg      <= '0;
         is_load_reg <= 1'b0;
         up_reg      <= 1'b0;
         first_reg   <= 1'b0;
         list_reg    <= '0;
      end else if (state_reg == IDLE) begin
         if (start) begin
            op_reg      <= cap_op;
            is_load_reg <= is_load;
            up_reg      <= up;
            first_reg   <= 1'b1;
            list_reg    <= reg_list;
         end
      end else if (state_reg == XFER && mfc) begin
         first_reg <= 1'b0;
         if (op_reg.mul)
            list_reg <= list_reg & ~cur_bit;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) begin
            if (!cap_op.legal || (cap_op.mul && reg_list == '0))
               state_next = ERR;
            else
               state_next = ADDR;
         end
         ADDR: state_next = XFER;
         XFER: begin
            if (mfc) begin
               if (op_reg.mul && rest_any)
                  state_next = ADDR;
               else if (op_reg.wb_need)
                  state_next = WB;
               else
                  state_next = DONE;
            end else if (tmo_hit) begin
               state_next = ERR;
            end
         end
         WB:      state_next = DONE;
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state; off_src is driven where the offset is consumed
   always_comb begin
      busy     = (state_reg != IDLE);
      mar_ld   = 1'b0;
      addr_src = SRC_RN;
      off_src  = 1'b0;
      mem_req  = 1'b0;
      mem_rw   = 1'b0;
      rd_ld    = 1'b0;
      reg_idx  = '0;
      rn_wb    = 1'b0;
      wb_src   = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      case (state_reg)
         ADDR: begin
            mar_ld   = 1'b1;
            addr_src = first_reg ? op_reg.first_src : SRC_MAR_4;
            off_src  = op_reg.reg_off;
            reg_idx  = (op_reg.mul && pick_any) ? pick_idx : 4'd0;
         end
         XFER: begin
            mem_req  = 1'b1;
            mem_rw   = is_load_reg;
            rd_ld    = mfc & is_load_reg;
            reg_idx  = (op_reg.mul && pick_any) ? pick_idx : 4'd0;
         end
         WB: begin
            rn_wb    = 1'b1;
            wb_src   = op_reg.mul;
            off_src  = op_reg.reg_off;
         end
         DONE:    done = 1'b1;
         ERR:     err  = 1'b1;
         default: ;
      endcase
   end

endmodule
